usage_timer_module: RTL and testbench
=====================================

USAGE_TIMER_MODULE -- requirements
Module: usage_timer_module

Interface
REQ-001 Parameter TICKS_PER_SEC, default 500: clk_500Hz cycles per counted second.
REQ-002 Parameter THR_W, default 32: width of reminder_threshold.
REQ-003 clk_500Hz  input  1  system clock, 500 Hz; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 run  input  1  level; 1 = accumulate time, 0 = hold.
REQ-006 clear_req  input  1  one-cycle pulse; zeroes accumulated time and returns to IDLE.
REQ-007 load_en  input  1  one-cycle pulse; loads load_value into total_seconds.
REQ-008 load_value  input  64  seconds value applied on load_en.
REQ-009 reminder_threshold  input  THR_W  seconds at which the reminder fires; 0 = reminder disabled.
REQ-010 reminder_ack  input  1  one-cycle pulse; drops the reminder output.
REQ-011 total_seconds  output  64  accumulated seconds, registered; feeds the h/m/s converter stage.
REQ-012 second_tick  output  1  one-cycle pulse, high in the cycle after each increment.
REQ-013 reminder  output  1  level; high from threshold reached until acknowledged.
REQ-014 state  output  2  current FSM state: IDLE=0, RUN=1, HOLD=2.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and HOLD, and encoding 3 SHALL never be reached.
REQ-016 Transitions: IDLE->RUN when run=1; RUN->HOLD when run=0; HOLD->RUN when run=1; any state->IDLE on clear_req.
REQ-017 The prescaler SHALL count 0..TICKS_PER_SEC-1 only while state=RUN, and SHALL hold its value in HOLD and IDLE.
REQ-018 On the edge where state=RUN and prescaler=TICKS_PER_SEC-1:
  - prescaler <= 0
  - total_seconds <= total_seconds+1
  - second_tick <= 1 for exactly one cycle
REQ-019 total_seconds SHALL saturate at 2^64-1: no wrap, no further second_tick, prescaler keeps wrapping.
REQ-020 clear_req SHALL set total_seconds=0, prescaler=0, reminder=0, fired flag=0 and state=IDLE on the same edge.
REQ-021 load_en SHALL set total_seconds=load_value, prescaler=0 and fired flag=0; state SHALL be unchanged.
REQ-022 Priority on simultaneous inputs SHALL be clear_req > load_en > count increment; a suppressed increment is lost, not deferred.
REQ-023 The reminder SHALL register high one cycle after total_seconds >= reminder_threshold, provided threshold != 0 and fired flag = 0; fired flag SHALL set on the same edge.
REQ-024 reminder_ack SHALL clear reminder on the next edge and leave fired flag set, so there is no re-assert until clear_req or load_en.
REQ-025 reminder_ack and the reminder-set condition in the same cycle: ack SHALL win only if reminder is already high; otherwise set wins.
REQ-026 A load_value at or above the threshold SHALL fire the reminder one cycle after the load.
REQ-027 run toggling mid-second SHALL preserve the prescaler phase, so partial seconds accumulate across HOLD.

Reset
REQ-028 While rst_n=0, outputs SHALL be total_seconds=0, second_tick=0, reminder=0 and state=IDLE; prescaler and fired flag SHALL be 0.
REQ-029 Reset assertion mid-second SHALL discard the partial second, with no increment on release.
REQ-030 The first edge after rst_n release SHALL evaluate normally; run=1 at release moves to RUN on that edge.

Structure
REQ-031 The shared package SHALL hold the state encodings (IDLE/RUN/HOLD), TICKS_PER_SEC default and the 64-bit time width constant.
REQ-032 The prescaler SHALL be a sub-module sec_prescaler with inputs en and sync_clr, and one-cycle output wrap; the FSM, saturating counter and reminder logic stay in the top module.

Verification
REQ-033 Reset, then run=1 held from edge 1: state=RUN after edge 1; total_seconds=1 after edge 501, =2 after edge 1001; second_tick high exactly 1 cycle each.
REQ-034 run=0 after 250 RUN cycles, held 1000 cycles, then run=1: the increment SHALL occur 250 RUN cycles after resume; total unchanged during HOLD.
REQ-035 load_value=2^64-2, run=1: one increment to 2^64-1, then no further change or second_tick over 2000 cycles.
REQ-036 threshold=3, run from 0: reminder rises 1 cycle after total_seconds=3; ack -> low next edge; it stays low at total 4, 5.
REQ-037 clear_req and load_en(load_value=100) on the increment edge: total_seconds=0, state=IDLE, reminder=0.
REQ-038 rst_n pulsed low for 3 cycles mid-second with total=7: total=0, state=IDLE; first increment exactly 500 RUN cycles after RUN is re-entered.

Source files
------------

// File: rtl/usage_timer_module_pkg.sv
// Purpose: shared encodings and width constants for the usage timer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package usage_timer_module_pkg;

  // Accumulated time is always carried as a 64-bit seconds count.
  localparam int TIME_W = 64;

  // Default number of clk_500Hz cycles that make up one counted second.
  localparam int TICKS_PER_SEC_DEF = 500;

  // Saturation ceiling of the seconds counter.
  localparam logic [TIME_W-1:0] TIME_MAX = '1;

  // FSM encodings; 2'd3 is never used.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/usage_timer_module_sec_prescaler.sv
// Purpose: divides clk_500Hz down to one wrap pulse per counted second.
// Latency: wrap is combinational from the count register; it is high during the last cycle of a second.
// Backpressure: none; en freezes the count in place, sync_clr restarts the second.
module sec_prescaler #(
  parameter int TICKS = 500
) (
  input  logic clk_500Hz,
  input  logic rst_n,
  input  logic en,
  input  logic sync_clr,
  output logic wrap
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The final cycle of a second is only meaningful while counting.
  assign wrap = en && (cnt_q == LAST);

  // Next count: restart wins, otherwise advance and roll over only when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (sync_clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register; reset discards any partial second.
  always_ff @(posedge clk_500Hz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/usage_timer_module.sv
// Purpose: run/hold usage timer with saturating 64-bit seconds count and a one-shot reminder.
// Latency: total_seconds/second_tick update on the wrap edge; reminder rises one edge after the threshold is met.
// Backpressure: none; run is a level, clear_req/load_en/reminder_ack are single-cycle pulses.
module usage_timer_module
  import usage_timer_module_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int THR_W         = 32
) (
  input  logic              clk_500Hz,
  input  logic              rst_n,
  input  logic              run,
  input  logic              clear_req,
  input  logic              load_en,
  input  logic [TIME_W-1:0] load_value,
  input  logic [THR_W-1:0]  reminder_threshold,
  input  logic              reminder_ack,
  output logic [TIME_W-1:0] total_seconds,
  output logic              second_tick,
  output logic              reminder,
  output logic [1:0]        state
);

  state_e            state_q,  state_d;
  logic [TIME_W-1:0] total_q,  total_d;
  logic              tick_q,   tick_d;
  logic              rem_q,    rem_d;
  logic              fired_q,  fired_d;

  logic              ps_en;
  logic              ps_clr;
  logic              ps_wrap;
  logic              at_max;
  logic              inc;
  logic [TIME_W-1:0] thr_ext;
  logic              thr_on;
  logic              set_cond;

  // The prescaler only advances in RUN, so HOLD keeps the partial second.
  // Clear and load both start a fresh second.
  assign ps_en  = (state_q == ST_RUN);
  assign ps_clr = clear_req | load_en;

  sec_prescaler #(
    .TICKS(TICKS_PER_SEC)
  ) u_prescaler (
    .clk_500Hz (clk_500Hz),
    .rst_n     (rst_n),
    .en        (ps_en),
    .sync_clr  (ps_clr),
    .wrap      (ps_wrap)
  );

  // Next state: run level steers IDLE/RUN/HOLD, clear_req overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (run)  state_d = ST_RUN;
      ST_RUN:  if (!run) state_d = ST_HOLD;
      ST_HOLD: if (run)  state_d = ST_RUN;
      default:           state_d = ST_IDLE;
    endcase
    if (clear_req) begin
      state_d = ST_IDLE;
    end
  end

  // An increment lost to clear/load is dropped, and the counter sticks at its ceiling.
  assign at_max = (total_q == TIME_MAX);
  assign inc    = ps_wrap && !clear_req && !load_en && !at_max;

  // Seconds counter and tick: clear > load > increment.
  always_comb begin
    total_d = total_q;
    tick_d  = 1'b0;
    if (clear_req) begin
      total_d = '0;
    end else if (load_en) begin
      total_d = load_value;
    end else if (inc) begin
      total_d = total_q + TIME_W'(1);
      tick_d  = 1'b1;
    end
  end

  // The reminder compares the registered count, so it trails the count by one edge.
  assign thr_ext  = TIME_W'(reminder_threshold);
  assign thr_on   = (reminder_threshold != '0);
  assign set_cond = thr_on && !fired_q && (total_q >= thr_ext);

  // Reminder and fired flag: the fired flag makes it one-shot until clear/load re-arms it.
  always_comb begin
    rem_d   = rem_q;
    fired_d = fired_q;
    if (clear_req) begin
      rem_d   = 1'b0;
      fired_d = 1'b0;
    end else if (load_en) begin
      // Re-arm; the new value is judged on the following edge.
      fired_d = 1'b0;
      if (reminder_ack) begin
        rem_d = 1'b0;
      end
    end else if (reminder_ack && rem_q) begin
      rem_d = 1'b0;
    end else if (set_cond) begin
      rem_d   = 1'b1;
      fired_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_500Hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      total_q <= '0;
      tick_q  <= 1'b0;
      rem_q   <= 1'b0;
      fired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      tick_q  <= tick_d;
      rem_q   <= rem_d;
      fired_q <= fired_d;
    end
  end

  assign total_seconds = total_q;
  assign second_tick   = tick_q;
  assign reminder      = rem_q;
  assign state         = state_q;

  // Encoding 3 is unreachable.
  a_no_state3: assert property (@(posedge clk_500Hz) disable iff (!rst_n)
    state_q != 2'd3);

  // Once saturated, only clear or load may move the count.
  a_saturate: assert property (@(posedge clk_500Hz) disable iff (!rst_n)
    (at_max && !clear_req && !load_en) |=> (total_q == TIME_MAX));

endmodule

// File: tb/tb_usage_timer_module.sv
module tb_usage_timer_module;

  logic        clk_500Hz = 1'b0;
  logic        rst_n;
  logic        run;
  logic        clear_req;
  logic        load_en;
  logic [63:0] load_value;
  logic [31:0] reminder_threshold;
  logic        reminder_ack;
  logic [63:0] total_seconds;
  logic        second_tick;
  logic        reminder;
  logic [1:0]  state;

  localparam logic [63:0] MAXV = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_RUN  = 2'd1;
  localparam logic [1:0]  S_HOLD = 2'd2;

  usage_timer_module #(
    .TICKS_PER_SEC (500),
    .THR_W         (32)
  ) dut (
    .clk_500Hz          (clk_500Hz),
    .rst_n              (rst_n),
    .run                (run),
    .clear_req          (clear_req),
    .load_en            (load_en),
    .load_value         (load_value),
    .reminder_threshold (reminder_threshold),
    .reminder_ack       (reminder_ack),
    .total_seconds      (total_seconds),
    .second_tick        (second_tick),
    .reminder           (reminder),
    .state              (state)
  );

  always #5 clk_500Hz = ~clk_500Hz;

  int edge_n = 0;
  always @(posedge clk_500Hz) edge_n++;

  typedef struct {
    int          cyc;
    logic [63:0] tot;
    logic [1:0]  st;
    logic        rem;
    logic        tick;
  } snap_t;

  typedef struct {
    int          cyc;
    logic [63:0] tot;
  } tick_t;

  snap_t snap_q[$];
  tick_t tick_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  task automatic snap(input int cyc, input logic [63:0] tot, input logic [1:0] st,
                      input logic rem, input logic tick);
    snap_t s;
    s.cyc = cyc; s.tot = tot; s.st = st; s.rem = rem; s.tick = tick;
    snap_q.push_back(s);
  endtask

  task automatic exp_tick(input int cyc, input logic [63:0] tot);
    tick_t t;
    t.cyc = cyc; t.tot = tot;
    tick_q.push_back(t);
  endtask

  task automatic wait_to(input int n);
    while (edge_n < n) @(negedge clk_500Hz);
  endtask

  // Monitor: compares scheduled snapshots and every second_tick against the queues.
  always @(negedge clk_500Hz) begin
    snap_t s;
    tick_t t;
    if (snap_q.size() > 0 && snap_q[0].cyc == edge_n) begin
      s = snap_q.pop_front();
      chk("total_seconds", total_seconds, s.tot);
      chk("state", {62'd0, state}, {62'd0, s.st});
      chk("reminder", {63'd0, reminder}, {63'd0, s.rem});
      chk("second_tick", {63'd0, second_tick}, {63'd0, s.tick});
    end
    if (tick_q.size() > 0 && tick_q[0].cyc < edge_n) begin
      t = tick_q.pop_front();
      checks++;
      errors++;
      $display("FAIL tick_missing at edge %0d: got none expected tick at edge %0d", edge_n, t.cyc);
    end
    if (second_tick) begin
      if (tick_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tick_unexpected at edge %0d: got tick expected none", edge_n);
      end else begin
        t = tick_q.pop_front();
        chk("tick_edge", 64'(edge_n), 64'(t.cyc));
        chk("tick_total", total_seconds, t.tot);
      end
    end
    if (edge_n > 20000) begin
      $display("FAIL watchdog at edge %0d: got no end expected finish", edge_n);
      $fatal(1, "watchdog");
    end
  end

  int b, c, d, e, f, g;

  initial begin
    rst_n = 1'b0; run = 1'b0; clear_req = 1'b0; load_en = 1'b0;
    load_value = '0; reminder_threshold = '0; reminder_ack = 1'b0;

    // Reset state.
    snap(2, 64'd0, S_IDLE, 1'b0, 1'b0);
    wait_to(3);

    // Release with run already high: RUN on the first edge, ticks every 500 RUN cycles.
    b = edge_n;
    rst_n = 1'b1; run = 1'b1;
    snap(b + 1,    64'd0, S_RUN, 1'b0, 1'b0);
    snap(b + 500,  64'd0, S_RUN, 1'b0, 1'b0);
    exp_tick(b + 501, 64'd1);
    snap(b + 502,  64'd1, S_RUN, 1'b0, 1'b0);
    exp_tick(b + 1001, 64'd2);
    snap(b + 1001, 64'd2, S_RUN, 1'b0, 1'b1);
    wait_to(b + 1001);

    // Hold mid-second: 250 RUN cycles, 1000 HOLD cycles, tick 250 RUN cycles after resume.
    c = edge_n;
    wait_to(c + 249);
    run = 1'b0;
    snap(c + 250,  64'd2, S_HOLD, 1'b0, 1'b0);
    snap(c + 800,  64'd2, S_HOLD, 1'b0, 1'b0);
    snap(c + 1250, 64'd2, S_RUN,  1'b0, 1'b0);
    snap(c + 1499, 64'd2, S_RUN,  1'b0, 1'b0);
    exp_tick(c + 1500, 64'd3);
    snap(c + 1500, 64'd3, S_RUN,  1'b0, 1'b1);
    wait_to(c + 1249);
    run = 1'b1;
    wait_to(c + 1500);

    // Clear, then reminder at threshold 3, ack, no re-assert at 4 and 5.
    d = edge_n;
    clear_req = 1'b1; reminder_threshold = 32'd3;
    snap(d + 1, 64'd0, S_IDLE, 1'b0, 1'b0);
    snap(d + 2, 64'd0, S_RUN,  1'b0, 1'b0);
    exp_tick(d + 502,  64'd1);
    exp_tick(d + 1002, 64'd2);
    exp_tick(d + 1502, 64'd3);
    snap(d + 1502, 64'd3, S_RUN, 1'b0, 1'b1);
    snap(d + 1503, 64'd3, S_RUN, 1'b1, 1'b0);
    snap(d + 1511, 64'd3, S_RUN, 1'b0, 1'b0);
    exp_tick(d + 2002, 64'd4);
    snap(d + 2003, 64'd4, S_RUN, 1'b0, 1'b0);
    exp_tick(d + 2502, 64'd5);
    snap(d + 2503, 64'd5, S_RUN, 1'b0, 1'b0);
    wait_to(d + 1);
    clear_req = 1'b0;
    wait_to(d + 1510);
    reminder_ack = 1'b1;
    wait_to(d + 1511);
    reminder_ack = 1'b0;

    // Clear and load together on the increment edge: clear wins, increment lost.
    wait_to(d + 3001);
    clear_req = 1'b1; load_en = 1'b1; load_value = 64'd100;
    e = d + 3002;
    snap(e,     64'd0, S_IDLE, 1'b0, 1'b0);
    snap(e + 1, 64'd0, S_RUN,  1'b0, 1'b0);
    wait_to(e);
    clear_req = 1'b0; load_en = 1'b0;

    // Load above threshold fires the reminder one edge later; state unchanged.
    wait_to(e + 9);
    load_en = 1'b1; load_value = 64'd10;
    snap(e + 10, 64'd10, S_RUN, 1'b0, 1'b0);
    snap(e + 11, 64'd10, S_RUN, 1'b1, 1'b0);
    snap(e + 12, 64'd10, S_RUN, 1'b0, 1'b0);
    exp_tick(e + 510, 64'd11);
    snap(e + 511, 64'd11, S_RUN, 1'b0, 1'b0);
    wait_to(e + 10);
    load_en = 1'b0;
    wait_to(e + 11);
    reminder_ack = 1'b1;
    wait_to(e + 12);
    reminder_ack = 1'b0;

    // Saturation: one increment to the ceiling, then silence for 2000+ cycles.
    f = e + 600;
    wait_to(f);
    reminder_threshold = 32'd0;
    load_en = 1'b1; load_value = 64'hFFFF_FFFF_FFFF_FFFE;
    snap(f + 1, 64'hFFFF_FFFF_FFFF_FFFE, S_RUN, 1'b0, 1'b0);
    exp_tick(f + 501, MAXV);
    snap(f + 501,  MAXV, S_RUN, 1'b0, 1'b1);
    snap(f + 2600, MAXV, S_RUN, 1'b0, 1'b0);
    wait_to(f + 1);
    load_en = 1'b0;
    wait_to(f + 2600);

    // Reset mid-second with total 7: partial second discarded.
    g = edge_n;
    load_en = 1'b1; load_value = 64'd7;
    snap(g + 1,   64'd7, S_RUN,  1'b0, 1'b0);
    snap(g + 201, 64'd0, S_IDLE, 1'b0, 1'b0);
    snap(g + 203, 64'd0, S_IDLE, 1'b0, 1'b0);
    snap(g + 204, 64'd0, S_RUN,  1'b0, 1'b0);
    snap(g + 703, 64'd0, S_RUN,  1'b0, 1'b0);
    exp_tick(g + 704, 64'd1);
    snap(g + 704, 64'd1, S_RUN,  1'b0, 1'b1);
    wait_to(g + 1);
    load_en = 1'b0;
    wait_to(g + 200);
    rst_n = 1'b0;
    wait_to(g + 203);
    rst_n = 1'b1;
    wait_to(g + 710);

    chk("snap_leftover", 64'(snap_q.size()), 64'd0);
    chk("tick_leftover", 64'(tick_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
